// File: rtl/hog_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// hog_ctrl_pkg : state encoding and error-bit indices for hog_frame_ctrl
// Rev 1.0
// ============================================================================
package hog_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_REQ = 3'd1,
        ST_READ     = 3'd2,
        ST_PRESENT  = 3'd3,
        ST_DRAIN    = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    localparam int ERR_BID  = 0;
    localparam int ERR_WDOG = 1;

endpackage
`default_nettype wire

// File: rtl/hog_ctrl_wdog.sv
`default_nettype none
// ============================================================================
// hog_ctrl_wdog : saturating inactivity counter, expires at all-ones
// Rev 1.0
// ============================================================================
module hog_ctrl_wdog #(
    parameter int WDOG_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [WDOG_W-1:0] r_cnt;

    // Leaving the watched states also restarts the count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (clr || !en) begin
            r_cnt <= '0;
        end else if (!expired) begin
            r_cnt <= r_cnt + WDOG_W'(1);
        end
    end

    assign expired = &r_cnt;

endmodule
`default_nettype wire

// File: rtl/hog_frame_ctrl.sv
`default_nettype none
// ============================================================================
// hog_frame_ctrl : frame sequencer feeding pixel words to the HOG engine and
//                  tracking emitted feature blocks. Optional watchdog: HOG_CTRL_WDOG_EN
// Rev 1.0
// ============================================================================
module hog_frame_ctrl
    import hog_ctrl_pkg::*;
#(
    parameter int PIX_W       = 8,
    parameter int PIX_N       = 96,
    parameter int MEM_AW      = 12,
    parameter int FRAME_WORDS = 160,
    parameter int BID_W       = 13,
    parameter int NUM_BLK     = 209,
    parameter int WDOG_W      = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [MEM_AW-1:0]        base_addr,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               err,
    output logic                     mem_rd_en,
    output logic [MEM_AW-1:0]        mem_addr,
    input  logic [PIX_W*PIX_N-1:0]   mem_rd_data,
    input  logic                     mem_rd_valid,
    input  logic                     hog_request,
    output logic                     hog_ready,
    output logic [PIX_W*PIX_N-1:0]   hog_data,
    input  logic                     hog_o_valid,
    input  logic [BID_W-1:0]         hog_bid
);

    localparam int WCNT_W = $clog2(FRAME_WORDS + 1);

    state_t              r_state;
    logic [WCNT_W-1:0]   r_word_cnt;
    logic [BID_W-1:0]    r_blk_cnt;
    logic [MEM_AW-1:0]   r_base;
    logic                w_wdog_exp;

`ifdef HOG_CTRL_WDOG_EN
    logic w_wdog_en;
    logic w_wdog_clr;

    assign w_wdog_en  = (r_state == ST_READ) || (r_state == ST_DRAIN);
    assign w_wdog_clr = mem_rd_valid || hog_o_valid;

    hog_ctrl_wdog #(
        .WDOG_W (WDOG_W)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_wdog_clr),
        .en      (w_wdog_en),
        .expired (w_wdog_exp)
    );
`else
    // An all-zero vector of the watchdog width reduces to a constant 0.
    localparam logic [WDOG_W-1:0] WDOG_NONE = '0;
    assign w_wdog_exp = &WDOG_NONE;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_word_cnt <= '0;
            r_blk_cnt  <= '0;
            r_base     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= '0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            hog_ready  <= 1'b0;
            hog_data   <= '0;
        end else begin
            mem_rd_en <= 1'b0;
            hog_ready <= 1'b0;
            done      <= 1'b0;

            // Block ids are checked against the running count in every active state.
            if (r_state != ST_IDLE && hog_o_valid) begin
                if (hog_bid != r_blk_cnt) begin
                    err[ERR_BID] <= 1'b1;
                end
                if (r_blk_cnt != BID_W'(NUM_BLK)) begin
                    r_blk_cnt <= r_blk_cnt + BID_W'(1);
                end
            end

            if (r_state != ST_IDLE && abort) begin
                r_state    <= ST_IDLE;
                busy       <= 1'b0;
                r_word_cnt <= '0;
                r_blk_cnt  <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            r_state    <= ST_WAIT_REQ;
                            busy       <= 1'b1;
                            err        <= '0;
                            r_word_cnt <= '0;
                            r_blk_cnt  <= '0;
                            r_base     <= base_addr;
                        end
                    end
                    ST_WAIT_REQ: begin
                        if (r_word_cnt == WCNT_W'(FRAME_WORDS)) begin
                            r_state <= ST_DRAIN;
                        end else if (hog_request) begin
                            mem_rd_en <= 1'b1;
                            mem_addr  <= r_base + MEM_AW'(r_word_cnt);
                            r_state   <= ST_READ;
                        end
                    end
                    ST_READ: begin
                        if (mem_rd_valid) begin
                            hog_data  <= mem_rd_data;
                            hog_ready <= 1'b1;
                            r_state   <= ST_PRESENT;
                        end else if (w_wdog_exp) begin
                            err[ERR_WDOG] <= 1'b1;
                            done          <= 1'b1;
                            r_state       <= ST_DONE;
                        end
                    end
                    ST_PRESENT: begin
                        r_word_cnt <= r_word_cnt + WCNT_W'(1);
                        r_state    <= ST_WAIT_REQ;
                    end
                    ST_DRAIN: begin
                        if (r_blk_cnt == BID_W'(NUM_BLK)) begin
                            done    <= 1'b1;
                            r_state <= ST_DONE;
                        end else if (w_wdog_exp) begin
                            err[ERR_WDOG] <= 1'b1;
                            done          <= 1'b1;
                            r_state       <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hog_frame_ctrl.sv
`default_nettype none
// ============================================================================
// tb_hog_frame_ctrl : directed table-driven bench for hog_frame_ctrl
// Rev 1.0
// ============================================================================
module tb_hog_frame_ctrl;

    localparam int DW = 768;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [11:0]   base_addr = '0;
    logic          busy;
    logic          done;
    logic [1:0]    err;
    logic          mem_rd_en;
    logic [11:0]   mem_addr;
    logic [DW-1:0] mem_rd_data;
    logic          mem_rd_valid;
    logic          hog_request = 1'b0;
    logic          hog_ready;
    logic [DW-1:0] hog_data;
    logic          hog_o_valid = 1'b0;
    logic [12:0]   hog_bid = '0;

    always #5 clk = ~clk;

    hog_frame_ctrl #(
        .PIX_W(8), .PIX_N(96), .MEM_AW(12), .FRAME_WORDS(4),
        .BID_W(13), .NUM_BLK(2), .WDOG_W(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .base_addr(base_addr),
        .busy(busy), .done(done), .err(err),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .mem_rd_valid(mem_rd_valid), .hog_request(hog_request), .hog_ready(hog_ready),
        .hog_data(hog_data), .hog_o_valid(hog_o_valid), .hog_bid(hog_bid)
    );

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [DW-1:0] mkdata(input logic [11:0] a);
        return {32{a, ~a}};
    endfunction

    // Memory model: answers each read strobe after 'lat' cycles (lat 0 = never).
    int            lat = 1;
    int            mcnt = 0;
    logic [11:0]   maddr = '0;
    logic          model_valid = 1'b0;
    logic          inj_valid = 1'b0;
    logic [DW-1:0] model_data = '0;
    logic [11:0]   addr_q[$];

    assign mem_rd_valid = model_valid | inj_valid;
    assign mem_rd_data  = model_data;

    always @(posedge clk) begin
        #1;
        model_valid = 1'b0;
        if (mcnt > 0) begin
            mcnt = mcnt - 1;
            if (mcnt == 0) begin
                model_valid = 1'b1;
                model_data  = mkdata(maddr);
            end
        end
        if (mem_rd_en) begin
            addr_q.push_back(mem_addr);
            maddr = mem_addr;
            mcnt  = lat;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [11:0]      base;
        int               lat;
        logic [12:0]      bid0;
        logic [12:0]      bid1;
        logic             poke;
        logic [3:0][11:0] addr;
        logic [1:0]       exp_err;
    } frame_vec_t;

    frame_vec_t vt[4];

    task automatic run_frame(input frame_vec_t v);
        addr_q.delete();
        lat       = v.lat;
        base_addr = v.base;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        base_addr = '0;
        check("busy_after_start", busy, 1);
        check("err_clear_on_start", err, 0);
        if (v.poke) begin
            start     = 1'b1;
            base_addr = 12'hABC;
            tick();
            start     = 1'b0;
        end
        for (int w = 0; w < 4; w++) begin
            int waited;
            waited = 0;
            hog_request = 1'b1;
            do begin
                tick();
                waited++;
            end while (!hog_ready && waited < 40);
            hog_request = 1'b0;
            check("ready_seen", hog_ready, 1);
            check_data("hog_data", hog_data, mkdata(v.addr[w]));
            if (w > 0) check("ready_spacing", waited, 3 + v.lat);
        end
        hog_o_valid = 1'b1;
        hog_bid     = v.bid0;
        tick();
        hog_bid     = v.bid1;
        tick();
        hog_o_valid = 1'b0;
        hog_bid     = '0;
        check("done_early", done, 0);
        tick();
        check("done_pulse", done, 1);
        check("err_at_done", err, v.exp_err);
        tick();
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        check("err_sticky", err, v.exp_err);
        check("addr_count", addr_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (addr_q.size() > i) check("mem_addr", addr_q[i], v.addr[i]);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        logic seen;
        int   waited;

        vt[0] = '{base: 12'h010, lat: 1, bid0: 13'd0, bid1: 13'd1, poke: 1'b0,
                  addr: {12'h013, 12'h012, 12'h011, 12'h010}, exp_err: 2'b00};
        vt[1] = '{base: 12'hFFE, lat: 1, bid0: 13'd0, bid1: 13'd1, poke: 1'b1,
                  addr: {12'h001, 12'h000, 12'hFFF, 12'hFFE}, exp_err: 2'b00};
        vt[2] = '{base: 12'h100, lat: 2, bid0: 13'd0, bid1: 13'd2, poke: 1'b0,
                  addr: {12'h103, 12'h102, 12'h101, 12'h100}, exp_err: 2'b01};
        vt[3] = '{base: 12'h7FF, lat: 3, bid0: 13'd0, bid1: 13'd1, poke: 1'b1,
                  addr: {12'h802, 12'h801, 12'h800, 12'h7FF}, exp_err: 2'b00};

        // Reset state
        rst = 1'b0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_ready", hog_ready, 0);
        check("rst_addr", mem_addr, 0);
        check_data("rst_data", hog_data, '0);
        rst = 1'b1;
        tick();

        for (int r = 0; r < 4; r++) run_frame(vt[r]);

        // abort together with start in IDLE: abort wins
        start = 1'b1; abort = 1'b1; base_addr = 12'h040;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort_beats_start", busy, 0);

        // Stray valid in WAIT_REQ, then abort while READ waits on a slow memory
        addr_q.delete();
        lat = 5; base_addr = 12'h020; start = 1'b1;
        tick();
        start = 1'b0;
        inj_valid = 1'b1;
        tick();
        inj_valid = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            tick();
            seen = seen | hog_ready;
        end
        check("stray_valid_ignored", seen, 0);
        hog_request = 1'b1;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!mem_rd_en && waited < 10);
        hog_request = 1'b0;
        check("abort_rd_en_seen", mem_rd_en, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy_drop", busy, 0);
        seen = 1'b0;
        repeat (8) begin
            tick();
            seen = seen | hog_ready | done;
        end
        check("abort_no_ready_done", seen, 0);
        check("abort_addr", (addr_q.size() > 0) ? addr_q[0] : 12'hFFF, 12'h020);
        check("abort_err_kept", err, 0);

        run_frame(vt[0]);

        // Memory never answers
        lat = 0; base_addr = 12'h300; start = 1'b1;
        tick();
        start = 1'b0;
        hog_request = 1'b1;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!mem_rd_en && waited < 10);
        hog_request = 1'b0;
        check("stall_rd_en_seen", mem_rd_en, 1);
`ifdef HOG_CTRL_WDOG_EN
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!done && waited < 40);
        check("wdog_done", done, 1);
        check("wdog_err", err, 2'b10);
        tick();
        check("wdog_idle", busy, 0);
`else
        seen = 1'b0;
        repeat (30) begin
            tick();
            seen = seen | done | hog_ready;
        end
        check("stall_no_done", seen, 0);
        check("stall_busy", busy, 1);
        check("stall_err", err, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("stall_abort", busy, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hog_frame_ctrl.md
# hog_frame_ctrl

Frame-level sequencer for the HOG pipeline. On a start pulse, it answers each row `request` from the HOG engine by reading one 96-pixel word from pixel memory and presenting it with a one-cycle `ready`. It also tracks `o_valid`/`bid` from the feature generator and pulses `done` once the last block of the frame has been emitted. It sits between the frame buffer memory and the `hog` top.

## Interface
- PIX_W, 8, pixel width
- PIX_N, 96, pixels per memory word (one HOG row word)
- MEM_AW, 12, pixel-memory word address width
- FRAME_WORDS, 160, words per frame
- BID_W, 13, block id width
- NUM_BLK, 209, feature blocks per frame
- WDOG_W, 16, watchdog counter width (used only with the macro)

- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-low
- start  in  1  frame start pulse; ignored while busy
- abort  in  1  cancel current frame
- base_addr  in  MEM_AW  first word address; sampled on accepted start
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse, frame complete
- err  out  2  sticky: [0] bid sequence mismatch, [1] watchdog expiry; cleared on accepted start
- mem_rd_en  out  1  one-cycle read strobe
- mem_addr  out  MEM_AW  read address
- mem_rd_data  in  PIX_W*PIX_N  read data
- mem_rd_valid  in  1  read data valid, any latency ≥1
- hog_request  in  1  HOG engine wants next word
- hog_ready  out  1  one-cycle pulse, hog_data valid
- hog_data  out  PIX_W*PIX_N  pixel word to HOG
- hog_o_valid  in  1  feature block valid
- hog_bid  in  BID_W  block id of feature block

## Operation
- States: IDLE, WAIT_REQ, READ, PRESENT, DRAIN, DONE.
- IDLE → WAIT_REQ on start. Clear word_cnt, blk_cnt and err. Latch base_addr.
- WAIT_REQ:
  - If word_cnt == FRAME_WORDS → DRAIN.
  - Else if hog_request → issue mem_rd_en with mem_addr = base + word_cnt, then → READ.
- READ: on mem_rd_valid, capture mem_rd_data into the data register → PRESENT. A hog_request seen in READ or PRESENT is not queued; the engine holds request until served.
- PRESENT: hog_ready = 1 for one cycle; word_cnt++; → WAIT_REQ.
- DRAIN: wait for blk_cnt == NUM_BLK → DONE. hog_request is ignored.
- DONE: done = 1 for one cycle → IDLE.
- Block tracking runs in every non-IDLE state. On each hog_o_valid:
  - If hog_bid ≠ blk_cnt, set err[0]. Counting continues regardless.
  - blk_cnt++, saturating at NUM_BLK.
- abort in any non-IDLE state: → IDLE next cycle. No done pulse. Counters cleared; err retained. If abort and start are asserted together, abort wins.
- mem_addr wraps modulo 2^MEM_AW.
- busy = (state ≠ IDLE).

## Timing
- Reset: state IDLE; busy, done, mem_rd_en, hog_ready = 0; err = 0; mem_addr, hog_data = 0.
- All outputs are registered.
- start sampled at cycle 0 → busy = 1 at cycle 1.
- hog_request sampled at t in WAIT_REQ → mem_rd_en at t+1. mem_rd_valid at t+1+L → hog_ready at t+2+L.
- Minimum spacing between hog_ready pulses: 4 cycles with L = 1.
- hog_o_valid completing the frame at cycle t → done at t+2 (DRAIN→DONE at t+1, pulse at t+2). If the final block arrives before all words are sent, DONE follows the last PRESENT via WAIT_REQ→DRAIN.
- mem_rd_valid outside READ is ignored.

## Configuration
- HOG_CTRL_WDOG_EN defined:
  - Watchdog counts cycles spent in READ or DRAIN and resets on every mem_rd_valid or hog_o_valid.
  - At all-ones it sets err[1] and goes to DONE, so done still pulses.
- Undefined: no watchdog logic; err[1] tied 0.

## Structure
- Package hog_ctrl_pkg holds:
  - state enum;
  - err bit index constants (ERR_BID = 0, ERR_WDOG = 1).
- Sub-module hog_ctrl_wdog (WDOG_W counter with clear/enable/expire), instantiated only under HOG_CTRL_WDOG_EN.

## Test plan
- Full frame, L = 1, FRAME_WORDS = 4, NUM_BLK = 2, base = 0x010:
  - reads 0x010–0x013 in order;
  - 4 hog_ready pulses with matching data;
  - bids 0,1 → done 2 cycles after last o_valid;
  - err = 0.
- Base 0xFFE, FRAME_WORDS = 4 → mem_addr 0xFFE, 0xFFF, 0x000, 0x001.
- Bid sequence 0,2 → err = 2'b01 sticky; done still pulses; next start clears err.
- abort in READ with L = 5:
  - busy drops next cycle; no hog_ready, no done;
  - late mem_rd_valid ignored;
  - new start works.
- start during busy ignored; base_addr change has no effect.
- With HOG_CTRL_WDOG_EN and WDOG_W = 4, mem_rd_valid never arrives → err = 2'b10 and done after 15 READ cycles. Without the macro → remains in READ.
